// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_pkg
// Purpose  : Shared address map, region type and decode helper for csr_bank.
// Revision : 1.0 - initial release
// ============================================================================
package csr_pkg;

  // Offsets for the default configuration (NUM_CFG = 8, NUM_STATUS = 4).
  localparam int unsigned DEF_NUM_CFG    = 8;
  localparam int unsigned DEF_NUM_STATUS = 4;
  localparam int unsigned IRQ_EN_OFS     = DEF_NUM_CFG;
  localparam int unsigned IRQ_PEND_OFS   = DEF_NUM_CFG + 1;
  localparam int unsigned STATUS_BASE    = DEF_NUM_CFG + 2;

  typedef enum logic [2:0] {
    CFG      = 3'd0,
    IRQEN    = 3'd1,
    IRQPEND  = 3'd2,
    STATUS   = 3'd3,
    UNMAPPED = 3'd4
  } region_e;

  // Classify a word address.  Ranges are tested by comparison only, so an
  // address beyond the map never turns into an out-of-range array index.
  function automatic region_e csr_decode(input logic [31:0] addr,
                                         input int unsigned num_cfg,
                                         input int unsigned num_status);
    region_e r;
    if (addr < num_cfg)                       r = CFG;
    else if (addr == num_cfg)                 r = IRQEN;
    else if (addr == num_cfg + 1)             r = IRQPEND;
    else if (addr < num_cfg + 2 + num_status) r = STATUS;
    else                                      r = UNMAPPED;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_bank_if
// Purpose  : Single-cycle write/read request bus between the AXI-Lite slave
//            (master side) and the register bank (slave side).
// Revision : 1.0 - initial release
// ============================================================================
interface csr_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic              wr_err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    input  wr_err, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    output wr_err, rd_data, rd_valid, rd_err
  );
endinterface
`default_nettype wire

// File: rtl/csr_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_irq_ctrl
// Purpose  : Interrupt enable mask, W1C pending latch and registered level irq.
// Revision : 1.0 - initial release
// ============================================================================
module csr_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  wire logic               clk,
  input  wire logic               resetn,
  input  wire logic               i_en_we,
  input  wire logic               i_pend_we,
  input  wire logic [NUM_IRQ-1:0] i_wdata,
  input  wire logic [NUM_IRQ-1:0] i_wmask,
  input  wire logic [NUM_IRQ-1:0] i_events,
  output logic      [NUM_IRQ-1:0] o_en,
  output logic      [NUM_IRQ-1:0] o_pend,
  output logic                    o_irq
);

  logic [NUM_IRQ-1:0] r_en;
  logic [NUM_IRQ-1:0] r_pend;
  logic               r_irq;
  logic [NUM_IRQ-1:0] w_clr;

  // Only bits written as 1 in an enabled byte lane are cleared.
  assign w_clr = i_pend_we ? (i_wdata & i_wmask) : '0;

  // Enable mask: byte-lane merge of the written value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_en <= '0;
    else if (i_en_we) r_en <= (r_en & ~i_wmask) | (i_wdata & i_wmask);
  end

  // Pending latch: events set, W1C clears, a simultaneous set wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pend <= '0;
    else         r_pend <= (r_pend & ~w_clr) | i_events;
  end

  // Level interrupt, one cycle behind the pending/enable state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_irq <= 1'b0;
    else         r_irq <= |(r_pend & r_en);
  end

  assign o_en   = r_en;
  assign o_pend = r_pend;
  assign o_irq  = r_irq;

endmodule
`default_nettype wire

// File: rtl/csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : csr_bank
// Purpose  : Shadowed config registers committed on frame_start, read-only
//            status registers and a W1C interrupt block.
// Revision : 1.0 - initial release
// ============================================================================
module csr_bank
  import csr_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 4,
  parameter int NUM_IRQ    = 8
) (
  input  wire logic                         clk,
  input  wire logic                         resetn,
  csr_bank_if.slave                         bus,
  input  wire logic                         i_frame_start,
  output logic      [NUM_CFG*DATA_W-1:0]    o_cfg_out,
  output logic                              o_cfg_pending,
  input  wire logic [NUM_STATUS*DATA_W-1:0] i_status_in,
  input  wire logic [NUM_IRQ-1:0]           i_irq_events,
  output logic                              o_irq
);

  localparam int unsigned c_STATUS_BASE = NUM_CFG + 2;

  // Parameter sanity checks at elaboration.
  if ((DATA_W % 8) != 0) begin : g_chk_data_w
    $error("csr_bank: DATA_W must be a multiple of 8");
  end
  if (NUM_IRQ > DATA_W) begin : g_chk_num_irq
    $error("csr_bank: NUM_IRQ must not exceed DATA_W");
  end
  if ((NUM_CFG + 2 + NUM_STATUS) > (2 ** ADDR_W)) begin : g_chk_map
    $error("csr_bank: register map does not fit in ADDR_W");
  end

  logic [DATA_W-1:0]   r_shadow    [NUM_CFG];
  logic [DATA_W-1:0]   r_committed [NUM_CFG];
  logic                r_cfg_pending;
  logic                r_wr_err;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_err;

  logic [DATA_W-1:0]   w_wmask;
  region_e             w_wr_rgn;
  region_e             w_rd_rgn;
  logic                w_wr_cfg;
  logic                w_wr_bad;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_rd_err;
  logic [NUM_IRQ-1:0]  w_irq_en;
  logic [NUM_IRQ-1:0]  w_irq_pend;

  // Expand byte strobes to a bit mask.
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_mask
    assign w_wmask[b*8 +: 8] = {8{bus.wr_strb[b]}};
  end

  assign w_wr_rgn = csr_decode(32'(bus.wr_addr), NUM_CFG, NUM_STATUS);
  assign w_rd_rgn = csr_decode(32'(bus.rd_addr), NUM_CFG, NUM_STATUS);
  assign w_wr_cfg = bus.wr_en && (w_wr_rgn == CFG);
  assign w_wr_bad = bus.wr_en && ((w_wr_rgn == STATUS) || (w_wr_rgn == UNMAPPED));

  // Shadow registers: byte-lane merge of CFG writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CFG; i++) r_shadow[i] <= '0;
    end else if (w_wr_cfg) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (bus.wr_addr == ADDR_W'(i))
          r_shadow[i] <= (r_shadow[i] & ~w_wmask) | (bus.wr_data & w_wmask);
      end
    end
  end

  // Atomic commit; copies the shadow as it stood before this cycle's write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CFG; i++) r_committed[i] <= '0;
    end else if (i_frame_start) begin
      for (int i = 0; i < NUM_CFG; i++) r_committed[i] <= r_shadow[i];
    end
  end

  // Pending flag: a CFG write in the commit cycle keeps it set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            r_cfg_pending <= 1'b0;
    else if (w_wr_cfg)      r_cfg_pending <= 1'b1;
    else if (i_frame_start) r_cfg_pending <= 1'b0;
  end

  // Write error pulse for read-only or unmapped targets.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_wr_err <= 1'b0;
    else         r_wr_err <= w_wr_bad;
  end

  // Read mux over pre-write state, so same-cycle writes are not visible.
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (w_rd_rgn)
      CFG: begin
        for (int i = 0; i < NUM_CFG; i++) begin
          if (bus.rd_addr == ADDR_W'(i)) w_rd_data = r_shadow[i];
        end
      end
      IRQEN:   w_rd_data[NUM_IRQ-1:0] = w_irq_en;
      IRQPEND: w_rd_data[NUM_IRQ-1:0] = w_irq_pend;
      STATUS: begin
        for (int j = 0; j < NUM_STATUS; j++) begin
          if (bus.rd_addr == ADDR_W'(c_STATUS_BASE + j))
            w_rd_data = i_status_in[j*DATA_W +: DATA_W];
        end
      end
      default: w_rd_err = 1'b1;
    endcase
  end

  // Registered read response, one cycle after the request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data <= w_rd_data;
        r_rd_err  <= w_rd_err;
      end else begin
        r_rd_err  <= 1'b0;
      end
    end
  end

  csr_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk       (clk),
    .resetn    (resetn),
    .i_en_we   (bus.wr_en && (w_wr_rgn == IRQEN)),
    .i_pend_we (bus.wr_en && (w_wr_rgn == IRQPEND)),
    .i_wdata   (bus.wr_data[NUM_IRQ-1:0]),
    .i_wmask   (w_wmask[NUM_IRQ-1:0]),
    .i_events  (i_irq_events),
    .o_en      (w_irq_en),
    .o_pend    (w_irq_pend),
    .o_irq     (o_irq)
  );

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg_out
    assign o_cfg_out[i*DATA_W +: DATA_W] = r_committed[i];
  end

  assign o_cfg_pending = r_cfg_pending;
  assign bus.wr_err    = r_wr_err;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_err    = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_bank
// Purpose  : Directed self-checking bench for csr_bank with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_bank;
  import csr_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  logic        clk;
  logic        resetn;
  logic        frame_start;
  logic [255:0] cfg_out;
  logic        cfg_pending;
  logic [127:0] status_in;
  logic [7:0]  irq_events;
  logic        irq;

  int checks = 0;
  int errors = 0;
  rd_exp_t sb[$];

  csr_bank_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  csr_bank #(
    .DATA_W(32), .ADDR_W(4), .NUM_CFG(8), .NUM_STATUS(4), .NUM_IRQ(8)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .i_frame_start (frame_start),
    .o_cfg_out     (cfg_out),
    .o_cfg_pending (cfg_pending),
    .i_status_in   (status_in),
    .i_irq_events  (irq_events),
    .o_irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cfg(input int i);
    return cfg_out[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic fs);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
    frame_start = fs;
    tick();
    bus.wr_en = 1'b0; frame_start = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] ed, input logic ee);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    sb.push_back('{data: ed, err: ee});
    tick();
    bus.rd_en = 1'b0;
    chk("rd_valid_latency", 32'(bus.rd_valid), 32'd1);
  endtask

  // Scoreboard: every read response is matched against the oldest request.
  always @(posedge clk) begin
    rd_exp_t e;
    #2;
    if (bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rd_unexpected: observed rd_valid 1 expected no response");
      end else begin
        e = sb.pop_front();
        chk("rd_data", bus.rd_data, e.data);
        chk("rd_err", 32'(bus.rd_err), 32'(e.err));
      end
    end
  end

  initial begin
    resetn = 1'b0; frame_start = 1'b0; status_in = '0; irq_events = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    tick(); tick();
    chk("rst_cfg0", cfg(0), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_wr_err", 32'(bus.wr_err), 32'd0);
    resetn = 1'b1;
    tick();

    // Shadow write then commit.
    wr(4'd0, 32'h0000_0780, 4'hF, 1'b0);
    chk("cfg0_before_commit", cfg(0), 32'd0);
    chk("pending_after_write", 32'(cfg_pending), 32'd1);
    chk("wr_err_cfg", 32'(bus.wr_err), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("cfg0_committed", cfg(0), 32'h0000_0780);
    chk("pending_cleared", 32'(cfg_pending), 32'd0);

    // Byte-lane merge, read returns shadow.
    wr(4'd1, 32'h1122_3344, 4'hF, 1'b0);
    wr(4'd1, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd(4'd1, 32'h11BB_33DD, 1'b0);
    chk("cfg1_not_committed", cfg(1), 32'd0);
    rd(4'd0, 32'h0000_0780, 1'b0);

    // Write coinciding with commit lands after the commit.
    wr(4'd2, 32'h0000_003C, 4'hF, 1'b1);
    chk("cfg2_unchanged", cfg(2), 32'd0);
    chk("cfg1_committed", cfg(1), 32'h11BB_33DD);
    chk("pending_kept", 32'(cfg_pending), 32'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("cfg2_committed", cfg(2), 32'h0000_003C);
    chk("pending_cleared2", 32'(cfg_pending), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("cfg2_recommit", cfg(2), 32'h0000_003C);

    // Interrupts.
    wr(4'(IRQ_EN_OFS), 32'hFFFF_FF05, 4'hF, 1'b0);
    rd(4'(IRQ_EN_OFS), 32'h0000_0005, 1'b0);
    irq_events = 8'h04; tick(); irq_events = 8'h00;
    chk("irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    rd(4'(IRQ_PEND_OFS), 32'h0000_0004, 1'b0);
    irq_events = 8'h04;
    wr(4'(IRQ_PEND_OFS), 32'h0000_0004, 4'hF, 1'b0);
    irq_events = 8'h00;
    chk("irq_set_wins", 32'(irq), 32'd1);
    tick();
    chk("irq_still_high", 32'(irq), 32'd1);
    irq_events = 8'h02; tick(); irq_events = 8'h00;
    wr(4'(IRQ_PEND_OFS), 32'h0000_0004, 4'hF, 1'b0);
    chk("irq_lag", 32'(irq), 32'd1);
    tick();
    chk("irq_fall", 32'(irq), 32'd0);
    rd(4'(IRQ_PEND_OFS), 32'h0000_0002, 1'b0);
    wr(4'(IRQ_PEND_OFS), 32'h0000_0002, 4'h0, 1'b0);
    rd(4'(IRQ_PEND_OFS), 32'h0000_0002, 1'b0);

    // Status and error paths.
    status_in[31:0] = 32'hDEAD_BEEF;
    rd(4'(STATUS_BASE), 32'hDEAD_BEEF, 1'b0);
    wr(4'(STATUS_BASE), 32'h1234_5678, 4'hF, 1'b0);
    chk("wr_err_status", 32'(bus.wr_err), 32'd1);
    tick();
    chk("wr_err_pulse_end", 32'(bus.wr_err), 32'd0);
    rd(4'(STATUS_BASE), 32'hDEAD_BEEF, 1'b0);
    wr(4'd15, 32'hFFFF_FFFF, 4'hF, 1'b0);
    chk("wr_err_unmapped", 32'(bus.wr_err), 32'd1);
    rd(4'd15, 32'd0, 1'b1);

    // Same-cycle read and write to one address returns the old value.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'h55; bus.wr_strb = 4'hF;
    rd(4'd3, 32'd0, 1'b0);
    bus.wr_en = 1'b0;
    rd(4'd3, 32'h55, 1'b0);

    // Back-to-back reads.
    bus.rd_en = 1'b1; bus.rd_addr = 4'd0;
    sb.push_back('{data: 32'h780, err: 1'b0});
    tick();
    chk("b2b_valid0", 32'(bus.rd_valid), 32'd1);
    bus.rd_addr = 4'd2;
    sb.push_back('{data: 32'h3C, err: 1'b0});
    tick();
    bus.rd_en = 1'b0;
    chk("b2b_valid1", 32'(bus.rd_valid), 32'd1);
    tick();
    chk("b2b_valid_drop", 32'(bus.rd_valid), 32'd0);

    // Reset with a read in flight and an uncommitted write.
    wr(4'd4, 32'h99, 4'hF, 1'b0);
    bus.rd_en = 1'b1; bus.rd_addr = 4'd4;
    #3 resetn = 1'b0;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    chk("rst_mid_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_mid_cfg0", cfg(0), 32'd0);
    chk("rst_mid_pending", 32'(cfg_pending), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    chk("rst_mid_rd_data", bus.rd_data, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    rd(4'd4, 32'd0, 1'b0);
    rd(4'd0, 32'd0, 1'b0);
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
